// File: rtl/v_ex_stage.sv
// Execute stage of the RV32I pipeline: operand select/forwarding, ALU, branch/jump resolution
// and the EX/MEM output register behind a valid/ready handshake.

// 32-bit ALU; C and V are meaningful only for ADD/SUB and read 0 otherwise.
module v_ex_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_c,
  output logic [3:0]      flags_c
);

  localparam int unsigned SHW = 5;
  localparam int unsigned XW  = XLEN + 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  logic [XLEN:0]    add_w;
  logic [XLEN:0]    sub_w;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             ovf;

  assign shamt = b_i[SHW-1:0];
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  // Subtract as a + ~b + 1 so C is the "no borrow" carry (C=1 when a >= b unsigned).
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + XW'(1);

  always_comb begin
    result_c = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_c = add_w[XLEN-1:0];
        carry    = add_w[XLEN];
        ovf      = (a_i[XLEN-1] == b_i[XLEN-1]) && (add_w[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_SUB: begin
        result_c = sub_w[XLEN-1:0];
        carry    = sub_w[XLEN];
        ovf      = (a_i[XLEN-1] != b_i[XLEN-1]) && (sub_w[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_SLL:  result_c = a_i << shamt;
      ALU_SLT:  result_c = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU: result_c = XLEN'(a_i < b_i);
      ALU_XOR:  result_c = a_i ^ b_i;
      ALU_SRL:  result_c = a_i >> shamt;
      ALU_SRA:  result_c = XLEN'($signed(a_i) >>> shamt);
      ALU_OR:   result_c = a_i | b_i;
      ALU_AND:  result_c = a_i & b_i;
      ALU_PASS: result_c = b_i;
      default:  result_c = '0;
    endcase
    flags_c = {(result_c == '0), result_c[XLEN-1], carry, ovf};
  end

endmodule

module v_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [3:0]            in_alu_op,
  input  logic                  in_a_sel,
  input  logic                  in_b_sel,
  input  logic [1:0]            in_fwd_a,
  input  logic [1:0]            in_fwd_b,
  input  logic [XLEN-1:0]       fwd_exmem,
  input  logic [XLEN-1:0]       fwd_memwb,
  input  logic                  in_br,
  input  logic [2:0]            in_br_f3,
  input  logic                  in_jump,
  input  logic                  in_jalr,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_we,
  input  logic                  in_mem_rd,
  input  logic                  in_mem_wr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [3:0]            out_flags,
  output logic [XLEN-1:0]       out_store,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_we,
  output logic                  out_mem_rd,
  output logic                  out_mem_wr,
  output logic                  out_redirect,
  output logic [XLEN-1:0]       out_target
);

  localparam logic [3:0] ALU_SUB = 4'd1;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_res;
  logic [3:0]      alu_flags;
  logic            br_taken;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] result;
  logic            accept;

  logic                  valid_q,    valid_d;
  logic                  redirect_q, redirect_d;
  logic [XLEN-1:0]       result_q,   result_d;
  logic [3:0]            flags_q,    flags_d;
  logic [XLEN-1:0]       store_q,    store_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic                  reg_we_q,   reg_we_d;
  logic                  mem_rd_q,   mem_rd_d;
  logic                  mem_wr_q,   mem_wr_d;
  logic [XLEN-1:0]       target_q,   target_d;

  // Forwarding muxes; code 11 falls back to the register file.
  always_comb begin
    case (in_fwd_a)
      2'b01:   rs1_fwd = fwd_exmem;
      2'b10:   rs1_fwd = fwd_memwb;
      default: rs1_fwd = in_rs1_data;
    endcase
    case (in_fwd_b)
      2'b01:   rs2_fwd = fwd_exmem;
      2'b10:   rs2_fwd = fwd_memwb;
      default: rs2_fwd = in_rs2_data;
    endcase
  end

  // Branches always compare rs1 against rs2 with a subtract, whatever the decode said.
  always_comb begin
    if (in_br) begin
      alu_op = ALU_SUB;
      alu_a  = rs1_fwd;
      alu_b  = rs2_fwd;
    end else begin
      alu_op = in_alu_op;
      alu_a  = in_a_sel ? in_pc  : rs1_fwd;
      alu_b  = in_b_sel ? in_imm : rs2_fwd;
    end
  end

  v_ex_alu #(.XLEN(XLEN)) u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_c (alu_res),
    .flags_c  (alu_flags)
  );

  // Branch condition from {Z,N,C,V}.
  always_comb begin
    case (in_br_f3)
      3'b000:  br_taken = alu_flags[3];
      3'b001:  br_taken = !alu_flags[3];
      3'b100:  br_taken = alu_flags[2] ^ alu_flags[0];
      3'b101:  br_taken = !(alu_flags[2] ^ alu_flags[0]);
      3'b110:  br_taken = !alu_flags[1];
      3'b111:  br_taken = alu_flags[1];
      default: br_taken = 1'b0;
    endcase
  end

  assign redirect = in_jump | (in_br & br_taken);
  assign target   = in_jalr ? ((rs1_fwd + in_imm) & ~XLEN'(1)) : (in_pc + in_imm);
  assign result   = in_jump ? (in_pc + XLEN'(4)) : alu_res;

  assign in_ready = !valid_q | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  // EX/MEM next state: flush beats accept, accept beats drain, otherwise hold.
  always_comb begin
    valid_d    = valid_q;
    redirect_d = redirect_q;
    result_d   = result_q;
    flags_d    = flags_q;
    store_d    = store_q;
    rd_d       = rd_q;
    reg_we_d   = reg_we_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    target_d   = target_q;
    if (flush) begin
      valid_d    = 1'b0;
      redirect_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      redirect_d = redirect;
      result_d   = result;
      flags_d    = alu_flags;
      store_d    = rs2_fwd;
      rd_d       = in_rd;
      reg_we_d   = in_reg_we & (in_rd != '0);
      mem_rd_d   = in_mem_rd;
      mem_wr_d   = in_mem_wr;
      target_d   = target;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      reg_we_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      target_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      reg_we_q   <= reg_we_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      target_q   <= target_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_redirect = redirect_q;
  assign out_result   = result_q;
  assign out_flags    = flags_q;
  assign out_store    = store_q;
  assign out_rd       = rd_q;
  assign out_reg_we   = reg_we_q;
  assign out_mem_rd   = mem_rd_q;
  assign out_mem_wr   = mem_wr_q;
  assign out_target   = target_q;

endmodule

// File: tb/tb_v_ex_stage.sv
// Scoreboard bench for v_ex_stage: directed cases plus randomized traffic against a
// behavioural model of the execute stage.
module tb_v_ex_stage;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm, fx, fm;
    logic [3:0]  op;
    logic        asel, bsel;
    logic [1:0]  fa, fb;
    logic        br;
    logic [2:0]  f3;
    logic        jump, jalr;
    logic [4:0]  rd;
    logic        we, mrd, mwr;
  } txn_t;

  typedef struct packed {
    logic [31:0] result, store, target;
    logic [3:0]  flags;
    logic [4:0]  rd;
    logic        we, mrd, mwr, redir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic [3:0]  in_alu_op = '0;
  logic        in_a_sel = 1'b0, in_b_sel = 1'b0;
  logic [1:0]  in_fwd_a = '0, in_fwd_b = '0;
  logic [31:0] fwd_exmem = '0, fwd_memwb = '0;
  logic        in_br = 1'b0;
  logic [2:0]  in_br_f3 = '0;
  logic        in_jump = 1'b0, in_jalr = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_we = 1'b0, in_mem_rd = 1'b0, in_mem_wr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result, out_store, out_target;
  logic [3:0]  out_flags;
  logic [4:0]  out_rd;
  logic        out_reg_we, out_mem_rd, out_mem_wr, out_redirect;

  int checks = 0;
  int failures = 0;

  exp_t offer_q[$];
  exp_t sb_q[$];
  bit   mv = 1'b0;
  bit   prev_flush = 1'b0;

  v_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
    .in_br(in_br), .in_br_f3(in_br_f3), .in_jump(in_jump), .in_jalr(in_jalr),
    .in_rd(in_rd), .in_reg_we(in_reg_we), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_store(out_store),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_redirect(out_redirect), .out_target(out_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: RV32I execute semantics in plain arithmetic.
  function automatic exp_t ref_model(input txn_t t);
    exp_t        e;
    logic [31:0] ra, rb, a, b, r;
    logic [32:0] wide;
    logic [3:0]  op;
    logic        c, v, taken;
    longint      sa, sb, sr;
    ra = (t.fa == 2'd1) ? t.fx : (t.fa == 2'd2) ? t.fm : t.rs1;
    rb = (t.fb == 2'd1) ? t.fx : (t.fb == 2'd2) ? t.fm : t.rs2;
    if (t.br) begin op = OP_SUB; a = ra; b = rb; end
    else begin op = t.op; a = t.asel ? t.pc : ra; b = t.bsel ? t.imm : rb; end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; wide = {1'b0, a} + {1'b0, b}; c = wide[32];
                     sr = sa + sb; v = (sr != longint'($signed(r))); end
      OP_SUB:  begin r = a - b; c = (a >= b); sr = sa - sb; v = (sr != longint'($signed(r))); end
      OP_SLL:  r = a << b[4:0];
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  r = a ^ b;
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_PASS: r = b;
      default: r = 32'd0;
    endcase
    case (t.f3)
      3'd0:    taken = (ra == rb);
      3'd1:    taken = (ra != rb);
      3'd4:    taken = ($signed(ra) < $signed(rb));
      3'd5:    taken = ($signed(ra) >= $signed(rb));
      3'd6:    taken = (ra < rb);
      3'd7:    taken = (ra >= rb);
      default: taken = 1'b0;
    endcase
    e.flags  = {(r == 32'd0), r[31], c, v};
    e.result = t.jump ? t.pc + 32'd4 : r;
    e.store  = rb;
    e.redir  = t.jump | (t.br & taken);
    e.target = t.jalr ? ((ra + t.imm) & 32'hFFFF_FFFE) : (t.pc + t.imm);
    e.rd     = t.rd;
    e.we     = t.we && (t.rd != 5'd0);
    e.mrd    = t.mrd;
    e.mwr    = t.mwr;
    return e;
  endfunction

  // Monitor: compare the presented bundle, then advance the handshake model.
  always @(negedge clk) begin
    exp_t e, off;
    bit   acc;
    if (!rst_n) begin
      mv = 1'b0; prev_flush = 1'b0;
      sb_q.delete(); offer_q.delete();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
      chk("out_valid", 32'(out_valid), 32'(mv));
      if (prev_flush) chk("redirect_after_flush", 32'(out_redirect), 32'd0);
      if (mv) begin
        e = sb_q[0];
        chk("result", out_result, e.result);
        chk("flags", 32'(out_flags), 32'(e.flags));
        chk("store", out_store, e.store);
        chk("rd", 32'(out_rd), 32'(e.rd));
        chk("reg_we", 32'(out_reg_we), 32'(e.we));
        chk("mem_rd", 32'(out_mem_rd), 32'(e.mrd));
        chk("mem_wr", 32'(out_mem_wr), 32'(e.mwr));
        chk("redirect", 32'(out_redirect), 32'(e.redir));
        if (e.redir) chk("target", out_target, e.target);
      end
      acc = in_valid && (!mv || out_ready);
      off = '0;
      if (in_valid) begin
        if (offer_q.size() == 0) chk("offer_queue_nonempty", 32'd0, 32'd1);
        else off = offer_q.pop_front();
      end
      if (flush) begin
        if (mv) sb_q.delete(0);
        mv = 1'b0;
      end else begin
        if (mv && out_ready) begin sb_q.delete(0); mv = 1'b0; end
        if (acc) begin sb_q.push_back(off); mv = 1'b1; end
      end
      prev_flush = flush;
    end
  end

  task automatic drive(input txn_t t, input bit v, input bit ordy, input bit fl);
    @(posedge clk); #1;
    in_pc = t.pc; in_rs1_data = t.rs1; in_rs2_data = t.rs2; in_imm = t.imm;
    fwd_exmem = t.fx; fwd_memwb = t.fm; in_alu_op = t.op;
    in_a_sel = t.asel; in_b_sel = t.bsel; in_fwd_a = t.fa; in_fwd_b = t.fb;
    in_br = t.br; in_br_f3 = t.f3; in_jump = t.jump; in_jalr = t.jalr;
    in_rd = t.rd; in_reg_we = t.we; in_mem_rd = t.mrd; in_mem_wr = t.mwr;
    in_valid = v; out_ready = ordy; flush = fl;
    if (v && rst_n) offer_q.push_back(ref_model(t));
  endtask

  // Issue one bundle with the sink ready, then sample its registered result.
  task automatic run1(input txn_t t);
    drive(t, 1'b1, 1'b1, 1'b0);
    drive(txn_t'(0), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 64));
      default: return $urandom;
    endcase
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    int   kind;
    t.pc = pick(); t.rs1 = pick(); t.rs2 = pick(); t.imm = pick();
    t.fx = pick(); t.fm = pick();
    t.op = 4'($urandom_range(0, 10));
    t.asel = 1'($urandom); t.bsel = 1'($urandom);
    t.fa = 2'($urandom); t.fb = 2'($urandom);
    t.f3 = 3'($urandom);
    kind = $urandom_range(0, 3);
    t.br = (kind == 1); t.jump = (kind >= 2); t.jalr = (kind == 3);
    t.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    t.we = 1'($urandom); t.mrd = 1'($urandom); t.mwr = 1'($urandom);
    return t;
  endfunction

  initial begin
    txn_t t, ta, tb;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD wrapping to zero
    t = '0; t.op = OP_ADD; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1; t.rd = 5'd5; t.we = 1'b1;
    run1(t);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'd0);
    chk("t1_flags", 32'(out_flags), 32'(4'b1010));

    // SUB with forwarded rs1 and immediate
    t = '0; t.op = OP_SUB; t.fa = 2'b01; t.fx = 32'h10; t.rs1 = 32'h777; t.bsel = 1'b1; t.imm = 32'd3;
    run1(t);
    chk("t2_result", out_result, 32'hD);

    // BLT taken, BLTU not taken on the same operands
    t = '0; t.op = OP_AND; t.br = 1'b1; t.f3 = 3'b100; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1;
    t.pc = 32'h100; t.imm = 32'hFFFF_FFF8;
    run1(t);
    chk("t3_blt_redirect", 32'(out_redirect), 32'd1);
    chk("t3_blt_target", out_target, 32'hF8);
    t.f3 = 3'b110;
    run1(t);
    chk("t3_bltu_redirect", 32'(out_redirect), 32'd0);

    // JALR
    t = '0; t.jump = 1'b1; t.jalr = 1'b1; t.rs1 = 32'h1001; t.imm = 32'd4; t.pc = 32'h200;
    t.rd = 5'd1; t.we = 1'b1;
    run1(t);
    chk("t4_target", out_target, 32'h1004);
    chk("t4_result", out_result, 32'h204);
    chk("t4_redirect", 32'(out_redirect), 32'd1);

    // Backpressure for three cycles, then release
    ta = '0; ta.op = OP_ADD; ta.rs1 = 32'd7; ta.rs2 = 32'd8;
    tb = '0; tb.op = OP_ADD; tb.rs1 = 32'd2; tb.rs2 = 32'd3;
    drive(ta, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(tb, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_stall_in_ready", 32'(in_ready), 32'd0);
      chk("t5_stall_result", out_result, 32'd15);
    end
    drive(tb, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_release_in_ready", 32'(in_ready), 32'd1);
    drive(txn_t'(0), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_next_result", out_result, 32'd5);

    // Flush while holding a jump and offering a new bundle
    ta = '0; ta.jump = 1'b1; ta.pc = 32'h40; ta.imm = 32'h20;
    drive(ta, 1'b1, 1'b1, 1'b0);
    drive(tb, 1'b1, 1'b0, 1'b0);
    drive(tb, 1'b1, 1'b1, 1'b1);
    drive(txn_t'(0), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_flush_valid", 32'(out_valid), 32'd0);
    chk("t6_flush_redirect", 32'(out_redirect), 32'd0);

    // Asynchronous reset in the middle of a stall
    ta = '0; ta.jump = 1'b1; ta.pc = 32'h80; ta.imm = 32'h8; ta.rd = 5'd3; ta.we = 1'b1;
    ta.mrd = 1'b1; ta.mwr = 1'b1; ta.rs2 = 32'hABCD;
    drive(ta, 1'b1, 1'b1, 1'b0);
    drive(tb, 1'b1, 1'b0, 1'b0);
    drive(tb, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_store", out_store, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_ctrl", 32'({out_reg_we, out_mem_rd, out_mem_wr, out_redirect}), 32'd0);
    chk("rst_target", out_target, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic with backpressure and occasional flush
    for (int i = 0; i < 800; i++) begin
      drive(rnd_txn(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0));
    end
    repeat (3) drive(txn_t'(0), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
